// File: rtl/rs_enc_packet_scheduler.sv
// Shares one serial RS encoder between two voice-frame requesters, one KSYMBOLS codeword per grant.
// Optional macro RS_SCHED_PAD_EN: zero-pads a codeword whose requester stalls for TIMEOUT cycles.
module rs_enc_packet_scheduler #(
    parameter int unsigned BITSPERSYMBOL = 8,
    parameter int unsigned KSYMBOLS      = 223,
    parameter int unsigned CHECKW        = 6,
    parameter int unsigned NUMCHECK0     = 32,
    parameter int unsigned NUMCHECK1     = 16,
    parameter int unsigned MAX_INFLIGHT  = 2
`ifdef RS_SCHED_PAD_EN
    ,
    parameter int unsigned TIMEOUT       = 64
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BITSPERSYMBOL-1:0] req0_data,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [BITSPERSYMBOL-1:0] req1_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    output logic [BITSPERSYMBOL-1:0] enc_data,
    output logic                     enc_valid,
    input  logic                     enc_ready,
    output logic                     enc_sop,
    output logic                     enc_eop,
    output logic                     enc_channel,
    output logic [CHECKW-1:0]        enc_numcheck,
    input  logic                     enc_out_valid,
    input  logic                     enc_out_ready,
    input  logic                     enc_out_eop,
    output logic [15:0]              cw_count0,
    output logic [15:0]              cw_count1,
    output logic [2:0]               inflight,
    output logic                     busy,
    output logic                     err_underflow
`ifdef RS_SCHED_PAD_EN
    ,
    output logic                     pad_event
`endif
);

    localparam int unsigned      SYM_W    = (KSYMBOLS > 1) ? $clog2(KSYMBOLS) : 1;
    localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(KSYMBOLS - 1);
    localparam logic [2:0]       MAX_IF   = 3'(MAX_INFLIGHT);
    localparam logic [CHECKW-1:0] NC0     = CHECKW'(NUMCHECK0);
    localparam logic [CHECKW-1:0] NC1     = CHECKW'(NUMCHECK1);
`ifdef RS_SCHED_PAD_EN
    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] LAST_IDLE = IDLE_W'(TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_PAD  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              chan_q, chan_d;
    logic [CHECKW-1:0] numcheck_q, numcheck_d;
    logic [SYM_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic [2:0]        inflight_q, inflight_d;
    logic [15:0]       cw0_q, cw0_d, cw1_q, cw1_d;
    logic              err_q, err_d;
`ifdef RS_SCHED_PAD_EN
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              pad_event_q, pad_event_d;
`endif

    logic g_valid_c, xfer_c, grant_c, pick_c, elig0_c, elig1_c, out_eop_c;

    // Datapath mux: granted requester passes straight through while a codeword is open
    always_comb begin
        enc_data   = '0;
        enc_valid  = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        g_valid_c  = chan_q ? req1_valid : req0_valid;
        case (state_q)
            S_XFER: begin
                enc_data   = chan_q ? req1_data : req0_data;
                enc_valid  = g_valid_c;
                req0_ready = !chan_q && enc_ready;
                req1_ready = chan_q && enc_ready;
            end
`ifdef RS_SCHED_PAD_EN
            S_PAD: enc_valid = 1'b1;
`endif
            default: ;
        endcase
    end

    assign enc_sop = enc_valid && (sym_cnt_q == '0);
    assign enc_eop = enc_valid && (sym_cnt_q == LAST_SYM);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        chan_d       = chan_q;
        numcheck_d   = numcheck_q;
        sym_cnt_d    = sym_cnt_q;
        inflight_d   = inflight_q;
        cw0_d        = cw0_q;
        cw1_d        = cw1_q;
        err_d        = err_q;
`ifdef RS_SCHED_PAD_EN
        idle_cnt_d   = idle_cnt_q;
        pad_event_d  = 1'b0;
`endif
        xfer_c    = enc_valid && enc_ready;
        out_eop_c = enc_out_valid && enc_out_ready && enc_out_eop;
        elig0_c   = req0_valid && (inflight_q < MAX_IF);
        elig1_c   = req1_valid && (inflight_q < MAX_IF);
        grant_c   = 1'b0;
        pick_c    = (elig0_c && elig1_c) ? !last_grant_q : !elig0_c;

        if (xfer_c) begin
            if (sym_cnt_q == LAST_SYM) begin
                sym_cnt_d = '0;
                state_d   = S_IDLE;
            end else begin
                sym_cnt_d = sym_cnt_q + SYM_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (elig0_c || elig1_c) begin
                    grant_c      = 1'b1;
                    chan_d       = pick_c;
                    last_grant_d = pick_c;
                    numcheck_d   = pick_c ? NC1 : NC0;
                    sym_cnt_d    = '0;
                    state_d      = S_XFER;
                    if (pick_c) cw1_d = cw1_q + 16'd1;
                    else        cw0_d = cw0_q + 16'd1;
                end
`ifdef RS_SCHED_PAD_EN
                idle_cnt_d = '0;
`endif
            end
`ifdef RS_SCHED_PAD_EN
            // Stall watchdog: only cycles with no offered symbol count towards the timeout
            S_XFER: begin
                if (xfer_c) begin
                    idle_cnt_d = '0;
                end else if (!g_valid_c) begin
                    if (idle_cnt_q == LAST_IDLE) begin
                        idle_cnt_d  = '0;
                        state_d     = S_PAD;
                        pad_event_d = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
            end
`endif
            default: ;
        endcase

        // Credits: a grant and an output eop in the same cycle cancel out
        if (grant_c && !out_eop_c) begin
            inflight_d = inflight_q + 3'd1;
        end else if (!grant_c && out_eop_c) begin
            if (inflight_q == 3'd0) err_d = 1'b1;
            else                    inflight_d = inflight_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            chan_q       <= 1'b0;
            numcheck_q   <= NC0;
            sym_cnt_q    <= '0;
            inflight_q   <= 3'd0;
            cw0_q        <= 16'd0;
            cw1_q        <= 16'd0;
            err_q        <= 1'b0;
`ifdef RS_SCHED_PAD_EN
            idle_cnt_q   <= '0;
            pad_event_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            chan_q       <= chan_d;
            numcheck_q   <= numcheck_d;
            sym_cnt_q    <= sym_cnt_d;
            inflight_q   <= inflight_d;
            cw0_q        <= cw0_d;
            cw1_q        <= cw1_d;
            err_q        <= err_d;
`ifdef RS_SCHED_PAD_EN
            idle_cnt_q   <= idle_cnt_d;
            pad_event_q  <= pad_event_d;
`endif
        end
    end

    assign enc_channel   = chan_q;
    assign enc_numcheck  = numcheck_q;
    assign cw_count0     = cw0_q;
    assign cw_count1     = cw1_q;
    assign inflight      = inflight_q;
    assign busy          = (state_q == S_XFER);
    assign err_underflow = err_q;
`ifdef RS_SCHED_PAD_EN
    assign pad_event     = pad_event_q;
`endif

endmodule

// File: tb/tb_rs_enc_packet_scheduler.sv
// Bench for rs_enc_packet_scheduler (KSYMBOLS=4, MAX_INFLIGHT=2): directed phases plus a random phase
// checked against a codeword-level model of per-requester symbol streams.
module tb_rs_enc_packet_scheduler;

    logic        clk, rst;
    logic [7:0]  req0_data, req1_data, enc_data;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic        enc_valid, enc_ready, enc_sop, enc_eop, enc_channel;
    logic [5:0]  enc_numcheck;
    logic        enc_out_valid, enc_out_ready, enc_out_eop;
    logic [15:0] cw_count0, cw_count1;
    logic [2:0]  inflight;
    logic        busy, err_underflow;
`ifdef RS_SCHED_PAD_EN
    logic        pad_event;
`endif

    rs_enc_packet_scheduler #(
        .KSYMBOLS(4),
        .MAX_INFLIGHT(2)
`ifdef RS_SCHED_PAD_EN
        ,
        .TIMEOUT(3)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .enc_data(enc_data), .enc_valid(enc_valid), .enc_ready(enc_ready),
        .enc_sop(enc_sop), .enc_eop(enc_eop), .enc_channel(enc_channel),
        .enc_numcheck(enc_numcheck),
        .enc_out_valid(enc_out_valid), .enc_out_ready(enc_out_ready), .enc_out_eop(enc_out_eop),
        .cw_count0(cw_count0), .cw_count1(cw_count1), .inflight(inflight),
        .busy(busy), .err_underflow(err_underflow)
`ifdef RS_SCHED_PAD_EN
        ,
        .pad_event(pad_event)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    logic [7:0] src0[$], src1[$];   // everything each requester has offered, in order
    logic       exp_order[$];       // expected channel of upcoming codewords (directed phases)
    int d0 = 0, d1 = 0;             // next symbol each requester offers
    int p0 = 0, p1 = 0;             // next symbol expected at the encoder, per requester
    int pos = 0, pend = 0;          // position in codeword; codewords fed but not yet emitted
    logic cur_ch = 1'b0;
    bit en0 = 0, en1 = 0, out_go = 0, extra_eop = 0, out_noise = 0, live = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, model the encoder side, return at next negedge
    task automatic step();
        logic pulse;
        req0_valid = en0 && (d0 < src0.size());
        req0_data  = req0_valid ? src0[d0] : 8'h00;
        req1_valid = en1 && (d1 < src1.size());
        req1_data  = req1_valid ? src1[d1] : 8'h00;
        pulse = extra_eop || (out_go && pend > 0);
        enc_out_valid = pulse;
        enc_out_ready = pulse;
        enc_out_eop   = pulse;
        if (!pulse && out_noise && $urandom_range(0, 1) == 1) begin
            enc_out_valid = 1'b1;
            enc_out_ready = 1'($urandom_range(0, 1));
        end
        #1;
        chk("inflight_max", 32'(inflight <= 3'd2), 32'd1);
        if (!enc_ready) chk("stall_ready", 32'({req0_ready, req1_ready}), 32'd0);
        if (enc_valid && enc_ready) begin
            if (live) begin
                if (pos == 0) begin
                    cur_ch = enc_channel;
                    if (exp_order.size() > 0) chk("grant_order", 32'(enc_channel), 32'(exp_order.pop_front()));
                end
                chk("channel_hold", 32'(enc_channel), 32'(cur_ch));
                chk("numcheck", 32'(enc_numcheck), cur_ch ? 32'd16 : 32'd32);
                chk("sop", 32'(enc_sop), 32'(pos == 0));
                chk("eop", 32'(enc_eop), 32'(pos == 3));
                chk("other_ready", 32'(cur_ch ? req0_ready : req1_ready), 32'd0);
                if (cur_ch) begin
                    if (p1 < src1.size()) chk("data1", 32'(enc_data), 32'(src1[p1]));
                    else chk("data1_extra", 32'd1, 32'd0);
                    p1++;
                end else begin
                    if (p0 < src0.size()) chk("data0", 32'(enc_data), 32'(src0[p0]));
                    else chk("data0_extra", 32'd1, 32'd0);
                    p0++;
                end
            end
            if (pos == 3) pend++;
            pos = (pos + 1) % 4;
        end
        if (req0_valid && req0_ready) d0++;
        if (req1_valid && req1_ready) d1++;
        if (pulse && pend > 0) pend--;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; en0 = 0; en1 = 0; out_go = 0; pend = 0;
        step(); step();
        rst = 1'b0; pos = 0;
    endtask

    task automatic drain();
        out_go = 1;
        for (int k = 0; k < 20 && pend > 0; k++) step();
        chk("drain_inflight", 32'(inflight), 32'd0);
    endtask

    initial begin
        rst = 1'b1; enc_ready = 1'b0;
        req0_data = '0; req0_valid = 0; req1_data = '0; req1_valid = 0;
        enc_out_valid = 0; enc_out_ready = 0; enc_out_eop = 0;
        @(negedge clk);

        // Reset with requester 0 already waiting, then a single codeword
        src0.push_back(8'h11); src0.push_back(8'h22); src0.push_back(8'h33); src0.push_back(8'h44);
        en0 = 1; exp_order.push_back(1'b0);
        step(); step();
        chk("rst_enc_valid", 32'(enc_valid), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_cw0", 32'(cw_count0), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_numcheck", 32'(enc_numcheck), 32'd32);
        chk("rst_channel", 32'(enc_channel), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        rst = 1'b0; enc_ready = 1'b1;
        step();
        chk("first_grant_busy", 32'(busy), 32'd1);
        chk("first_grant_cw0", 32'(cw_count0), 32'd1);
        chk("first_grant_inflight", 32'(inflight), 32'd1);
        for (int k = 0; k < 4; k++) step();
        chk("single_done_busy", 32'(busy), 32'd0);
        chk("single_cw0", 32'(cw_count0), 32'd1);
        chk("single_sent", 32'(p0), 32'd4);
        drain();

        // Round-robin with both requesters continuously valid
        do_reset();
        for (int k = 0; k < 8; k++) begin src0.push_back(8'($urandom)); src1.push_back(8'($urandom)); end
        exp_order.push_back(1'b0); exp_order.push_back(1'b1); exp_order.push_back(1'b0); exp_order.push_back(1'b1);
        en0 = 1; en1 = 1; out_go = 1; enc_ready = 1'b1;
        for (int k = 0; k < 60 && !(p0 == src0.size() && p1 == src1.size()); k++) step();
        drain();
        chk("rr_cw0", 32'(cw_count0), 32'd2);
        chk("rr_cw1", 32'(cw_count1), 32'd2);
        chk("rr_order_done", 32'(exp_order.size()), 32'd0);

        // Backpressure: enc_ready toggles every cycle
        for (int k = 0; k < 4; k++) begin src0.push_back(8'($urandom)); src1.push_back(8'($urandom)); end
        exp_order.push_back(1'b0); exp_order.push_back(1'b1);
        for (int k = 0; k < 60 && !(p0 == src0.size() && p1 == src1.size()); k++) begin
            enc_ready = (k % 2 == 0);
            step();
        end
        enc_ready = 1'b1;
        drain();
        chk("bp_cw0", 32'(cw_count0), 32'd3);
        chk("bp_cw1", 32'(cw_count1), 32'd3);
        chk("bp_all_sent", 32'(p0 + p1), 32'(src0.size() + src1.size()));

        // Credit limit: no output eops, two codewords outstanding
        out_go = 0;
        for (int k = 0; k < 8; k++) src0.push_back(8'($urandom));
        for (int k = 0; k < 4; k++) src1.push_back(8'($urandom));
        exp_order.push_back(1'b0); exp_order.push_back(1'b1); exp_order.push_back(1'b0);
        for (int k = 0; k < 15; k++) step();
        chk("credit_inflight", 32'(inflight), 32'd2);
        chk("credit_busy", 32'(busy), 32'd0);
        chk("credit_cw0", 32'(cw_count0), 32'd4);
        chk("credit_cw1", 32'(cw_count1), 32'd4);
        chk("credit_blocked", 32'(p0), 32'(src0.size() - 4));
        out_go = 1;
        step();
        chk("credit_release_inflight", 32'(inflight), 32'd1);
        chk("credit_release_busy", 32'(busy), 32'd0);
        step();
        chk("grant_and_eop_inflight", 32'(inflight), 32'd1);
        chk("grant_and_eop_busy", 32'(busy), 32'd1);
        chk("grant_and_eop_cw0", 32'(cw_count0), 32'd5);
        out_go = 0;
        for (int k = 0; k < 4; k++) step();
        chk("credit_third_done", 32'(busy), 32'd0);
        out_go = 1;
        step();
        chk("credit_empty", 32'(inflight), 32'd0);
        chk("no_underflow_yet", 32'(err_underflow), 32'd0);
        out_go = 0; extra_eop = 1;
        step();
        extra_eop = 0;
        chk("underflow_flag", 32'(err_underflow), 32'd1);
        chk("underflow_inflight", 32'(inflight), 32'd0);

        // Random traffic, backpressure and encoder drain
        do_reset();
        chk("rst2_err", 32'(err_underflow), 32'd0);
        chk("rst2_cw1", 32'(cw_count1), 32'd0);
        begin
            int n0, n1;
            n0 = $urandom_range(3, 7);
            n1 = $urandom_range(3, 7);
            for (int k = 0; k < 4 * n0; k++) src0.push_back(8'($urandom));
            for (int k = 0; k < 4 * n1; k++) src1.push_back(8'($urandom));
            out_noise = 1;
            for (int k = 0; k < 4000; k++) begin
                if (p0 == src0.size() && p1 == src1.size() && pend == 0) break;
                en0 = ($urandom_range(0, 3) != 0);
                en1 = ($urandom_range(0, 3) != 0);
                enc_ready = ($urandom_range(0, 3) != 0);
                out_go = ($urandom_range(0, 2) == 0);
                step();
            end
            out_noise = 0; enc_ready = 1'b1;
            chk("rand_sent0", 32'(p0), 32'(src0.size()));
            chk("rand_sent1", 32'(p1), 32'(src1.size()));
            chk("rand_cw0", 32'(cw_count0), 32'(n0));
            chk("rand_cw1", 32'(cw_count1), 32'(n1));
            chk("rand_inflight", 32'(inflight), 32'd0);
            chk("rand_err", 32'(err_underflow), 32'd0);
        end

`ifdef RS_SCHED_PAD_EN
        // Requester 0 stalls after two symbols; the codeword is zero-padded
        do_reset();
        src0.push_back(8'h5a); src0.push_back(8'ha5);
        en0 = 1; en1 = 0; out_go = 1; enc_ready = 1'b1;
        step(); step(); step();
        live = 0;
        step(); step();
        chk("pad_not_yet", 32'(pad_event), 32'd0);
        chk("pad_wait_valid", 32'(enc_valid), 32'd0);
        step();
        chk("pad_event", 32'(pad_event), 32'd1);
        chk("pad_valid", 32'(enc_valid), 32'd1);
        chk("pad_data0", 32'(enc_data), 32'd0);
        chk("pad_ready", 32'(req0_ready), 32'd0);
        chk("pad_eop0", 32'(enc_eop), 32'd0);
        step();
        chk("pad_pulse_end", 32'(pad_event), 32'd0);
        chk("pad_data1", 32'(enc_data), 32'd0);
        chk("pad_eop1", 32'(enc_eop), 32'd1);
        step();
        chk("pad_idle_valid", 32'(enc_valid), 32'd0);
        chk("pad_idle_busy", 32'(busy), 32'd0);
        live = 1;
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
